// File: rtl/data_memory_responder.sv
// Word-addressed data memory answering CPU load/store requests over req/ack.
// One request in flight at a time; a countdown models the fixed access latency.
module data_memory_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic [31:0] mem_q [DEPTH];

  logic                  capture;
  logic                  access;
  logic                  acc_we;
  logic                  acc_err;
  logic                  mem_wr;
  logic [31:0]           acc_addr;
  logic [31:0]           acc_wdata;
  logic [3:0]            acc_be;
  logic [DEPTH_LOG2-1:0] acc_idx;

  // With LATENCY=1 the access shares the capture edge, so operands bypass the capture registers.
  always_comb begin
    capture   = (state_q == S_IDLE) && req_i;
    access    = rst_i && (((LATENCY == 1) && capture) ||
                          ((state_q == S_WAIT) && (cnt_q == 4'd1)));
    acc_we    = capture ? we_i    : we_q;
    acc_addr  = capture ? addr_i  : addr_q;
    acc_wdata = capture ? wdata_i : wdata_q;
    acc_be    = capture ? be_i    : be_q;
    acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= 30'(DEPTH));
    acc_idx   = acc_addr[DEPTH_LOG2+1:2];
    mem_wr    = access && acc_we && !acc_err;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      ack_o   <= 1'b0;
      rdata_o <= 32'd0;
      err_o   <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      ack_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_i) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            be_q    <= be_i;
            cnt_q   <= 4'(LATENCY - 1);
            busy_o  <= 1'b1;
            state_q <= (LATENCY == 1) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          busy_o  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_o  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase

      // Response registers change only on the RESP-entry edge; stores leave rdata untouched.
      if (access) begin
        ack_o <= 1'b1;
        err_o <= acc_err;
        if (acc_err) begin
          rdata_o <= 32'd0;
        end else if (!acc_we) begin
          rdata_o <= mem_q[acc_idx];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) begin
          mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: a LATENCY=3 and a LATENCY=1 instance checked every
// cycle against a transaction-timeline model, plus directed load/store scenarios.
module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [1:0]  ack;
  logic [1:0]  err;
  logic [1:0]  busy;
  logic [31:0] rdata [2];

  always #5 clk = ~clk;

  data_memory_responder #(.DEPTH_LOG2(8), .LATENCY(3)) dut0 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req[0]), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .ack_o(ack[0]), .rdata_o(rdata[0]),
    .err_o(err[0]), .busy_o(busy[0])
  );

  data_memory_responder #(.DEPTH_LOG2(8), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req[1]), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .ack_o(ack[1]), .rdata_o(rdata[1]),
    .err_o(err[1]), .busy_o(busy[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lat(input int k);
    return (k == 0) ? 3 : 1;
  endfunction

  // Timeline model: a request accepted at edge n is answered at edge n+L-1,
  // keeps the block busy through that response cycle, and the next request
  // can be accepted from edge n+L+1 onwards.
  int          edge_n = 0;
  int          free_at [2] = '{0, 0};
  int          resp_at [2] = '{0, 0};
  bit          pend    [2] = '{0, 0};
  bit          op_we   [2];
  logic [31:0] op_addr [2];
  logic [31:0] op_wdata[2];
  logic [3:0]  op_be   [2];
  logic [31:0] mm [2][256];
  bit   [3:0]  kb [2][256];
  bit          e_ack [2] = '{0, 0};
  bit          e_busy[2] = '{0, 0};
  bit          e_err [2] = '{0, 0};
  bit          e_rk  [2] = '{1, 1};
  logic [31:0] e_rd  [2] = '{32'd0, 32'd0};

  task automatic respond(input int k);
    logic [31:0] a;
    int          w;
    bit          bad;
    a   = op_addr[k];
    bad = (a % 4 != 0) || (a / 4 >= 256);
    w   = bad ? 0 : int'(a / 4);
    e_err[k] = bad;
    if (bad) begin
      e_rd[k] = 32'd0;
      e_rk[k] = 1'b1;
    end else if (op_we[k]) begin
      for (int b = 0; b < 4; b++) begin
        if (op_be[k][b]) begin
          mm[k][w][8*b +: 8] = op_wdata[k][8*b +: 8];
          kb[k][w][b] = 1'b1;
        end
      end
    end else begin
      e_rd[k] = mm[k][w];
      e_rk[k] = (kb[k][w] == 4'hF);
    end
    $display("txn dut%0d edge=%0d %s addr=%h wdata=%h be=%h err=%0d rdata=%h",
             k, edge_n, op_we[k] ? "store" : "load ", a, op_wdata[k], op_be[k],
             bad, e_rd[k]);
  endtask

  always @(posedge clk) begin
    edge_n++;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        pend[k]    = 1'b0;
        free_at[k] = 0;
        e_ack[k]   = 1'b0;
        e_busy[k]  = 1'b0;
        e_err[k]   = 1'b0;
        e_rd[k]    = 32'd0;
        e_rk[k]    = 1'b1;
      end else begin
        e_ack[k] = 1'b0;
        if (edge_n >= free_at[k] && req[k]) begin
          op_we[k]    = we;
          op_addr[k]  = addr;
          op_wdata[k] = wdata;
          op_be[k]    = be;
          resp_at[k]  = edge_n + lat(k) - 1;
          free_at[k]  = edge_n + lat(k) + 1;
          pend[k]     = 1'b1;
        end
        if (pend[k] && edge_n == resp_at[k]) begin
          respond(k);
          pend[k]  = 1'b0;
          e_ack[k] = 1'b1;
        end
        e_busy[k] = (edge_n < free_at[k] - 1);
      end
    end
  end

  always @(posedge clk) begin
    #2;
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("ack%0d", k),  32'(ack[k]),  32'(e_ack[k]));
      check_val($sformatf("busy%0d", k), 32'(busy[k]), 32'(e_busy[k]));
      check_val($sformatf("err%0d", k),  32'(err[k]),  32'(e_err[k]));
      if (e_rk[k]) begin
        check_val($sformatf("rdata%0d", k), rdata[k], e_rd[k]);
      end
    end
  end

  task automatic txn(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, output logic [31:0] rd, output logic er);
    int t = 0;
    @(negedge clk);
    we = w; addr = a; wdata = d; be = b; req[k] = 1'b1;
    @(negedge clk);
    req[k] = 1'b0;
    while (!ack[k] && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_val("ack_seen", 32'(ack[k]), 32'd1);
    rd = rdata[k];
    er = err[k];
    @(negedge clk);
  endtask

  task automatic held(input int k);
    int acks = 0;
    @(negedge clk);
    we = 1'b0; addr = 32'h10; be = 4'hF; req[k] = 1'b1;
    for (int i = 1; i < 3; i++) begin
      repeat (lat(k) + 1) begin
        @(negedge clk);
        acks += int'(ack[k]);
      end
      addr = 32'h10 + 32'(4 * i);
    end
    @(negedge clk);
    acks += int'(ack[k]);
    req[k] = 1'b0;
    repeat (2 * lat(k) + 6) begin
      @(negedge clk);
      acks += int'(ack[k]);
    end
    check_val($sformatf("held_acks%0d", k), 32'(acks), 32'd3);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    rst_n = 1'b0; req = 2'b00; we = 1'b0; addr = '0; wdata = '0; be = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_val("rst_ack",   32'(ack[k]),  32'd0);
      check_val("rst_busy",  32'(busy[k]), 32'd0);
      check_val("rst_err",   32'(err[k]),  32'd0);
      check_val("rst_rdata", rdata[k],     32'd0);
    end
    rst_n = 1'b1;

    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er);
    check_val("st_err", 32'(er), 32'd0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er);
    check_val("ld_data", rd, 32'hDEADBEEF);
    check_val("ld_err", 32'(er), 32'd0);
    repeat (5) @(negedge clk);
    check_val("ld_hold", rdata[0], 32'hDEADBEEF);

    txn(0, 1'b1, 32'h10, 32'h00000011, 4'b0001, rd, er);
    check_val("st_hold_rdata", rd, 32'hDEADBEEF);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er);
    check_val("lane_data", rd, 32'hDEADBE11);

    txn(0, 1'b0, 32'h13, 32'h0, 4'hF, rd, er);
    check_val("mis_err", 32'(er), 32'd1);
    check_val("mis_data", rd, 32'd0);
    txn(0, 1'b0, 32'h400, 32'h0, 4'hF, rd, er);
    check_val("oor_err", 32'(er), 32'd1);
    check_val("oor_data", rd, 32'd0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, er);
    check_val("after_err_data", rd, 32'hDEADBE11);
    check_val("after_err_err", 32'(er), 32'd0);

    txn(0, 1'b1, 32'h14, 32'h5A5A5A5A, 4'b0000, rd, er);
    check_val("be0_err", 32'(er), 32'd0);

    held(0);
    held(1);

    txn(0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, rd, er);
    @(negedge clk);
    we = 1'b1; addr = 32'h20; wdata = 32'h12345678; be = 4'hF; req[0] = 1'b1;
    @(negedge clk);
    req[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_val("abort_ack",   32'(ack[0]),  32'd0);
      check_val("abort_busy",  32'(busy[0]), 32'd0);
      check_val("abort_err",   32'(err[0]),  32'd0);
      check_val("abort_rdata", rdata[0],     32'd0);
    end
    rst_n = 1'b1;
    txn(0, 1'b0, 32'h20, 32'h0, 4'hF, rd, er);
    check_val("abort_keep", rd, 32'hCAFEF00D);

    repeat (800) begin
      @(negedge clk);
      rst_n  = ($urandom_range(0, 99) != 0);
      req[0] = ($urandom_range(0, 2) == 0);
      req[1] = ($urandom_range(0, 2) == 0);
      we     = 1'($urandom_range(0, 1));
      wdata  = $urandom;
      be     = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 7))
        6:       addr = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
        7:       addr = 32'h400 + $urandom;
        default: addr = 32'($urandom_range(0, 15) * 4);
      endcase
      if (addr < 32'h400 && addr[1:0] == 2'b00 && $urandom_range(0, 9) == 0) begin
        addr = 32'h400 + 32'($urandom_range(0, 255) * 4);
      end
    end
    @(negedge clk);
    rst_n = 1'b1; req = 2'b00;
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
